// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: round-robin scan of a 4:1 mux, sampling each input after a settle time.
// Latency: DWELL+1 cycles per channel; done pulses 1+4*(DWELL+1) cycles after start is accepted.
// Backpressure: none; start is only honoured in IDLE (or in DONE when continuous mode is built in).
//
// Optional feature macro: MUX_SCAN_CONT_EN (continuous back-to-back frames when start is high in DONE).
// Ports:
//   clk, rst      single clock, synchronous active-high reset
//   i_start       scan request
//   i_mux_out     mux output bit being scanned
//   o_sel         mux select, 0..3
//   o_samples     captured bits, o_samples[n] = mux input n
//   o_busy        high from SETTLE entry until DONE exits
//   o_done        one-cycle pulse per completed frame
module mux_scan_ctrl #(
   parameter int unsigned DWELL = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_start,
   input  logic       i_mux_out,
   output logic [1:0] o_sel,
   output logic [3:0] o_samples,
   output logic       o_busy,
   output logic       o_done
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   localparam logic [7:0] LP_LAST = 8'(DWELL - 1);

   state_t     r_state;
   logic [7:0] r_cnt;
   logic [1:0] r_sel;
   logic [3:0] r_samples;
   logic       r_busy;
   logic       r_done;

   logic       w_last;
   logic       w_restart;

   assign w_last = (r_cnt == LP_LAST);

   // Continuous mode lets a start seen in DONE launch the next frame with no IDLE gap.
`ifdef MUX_SCAN_CONT_EN
   assign w_restart = i_start;
`else
   assign w_restart = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= 8'd0;
         r_sel     <= 2'd0;
         r_samples <= 4'b0000;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state   <= ST_SETTLE;
                  r_sel     <= 2'd0;
                  r_samples <= 4'b0000;
                  r_cnt     <= 8'd0;
                  r_busy    <= 1'b1;
               end
            end
            ST_SETTLE: begin
               r_cnt <= r_cnt + 8'd1;
               if (w_last) begin
                  r_state <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               r_samples[r_sel] <= i_mux_out;
               // sel stops at 3; returning to 0 happens only on a fresh start.
               if (r_sel == 2'd3) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_sel   <= r_sel + 2'd1;
                  r_cnt   <= 8'd0;
                  r_state <= ST_SETTLE;
               end
            end
            ST_DONE: begin
               if (w_restart) begin
                  r_state   <= ST_SETTLE;
                  r_sel     <= 2'd0;
                  r_samples <= 4'b0000;
                  r_cnt     <= 8'd0;
               end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_sel     = r_sel;
   assign o_samples = r_samples;
   assign o_busy    = r_busy;
   assign o_done    = r_done;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: exercises three scan controllers (DWELL 2, 1 and 255) against a frame-level model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_mux_scan_ctrl;

   logic clk;
   logic rst;

   logic       a_start, a_mux, a_busy, a_done;
   logic [3:0] a_in, a_smp;
   logic [1:0] a_sel;
   logic       b_start, b_mux, b_busy, b_done;
   logic [3:0] b_in, b_smp;
   logic [1:0] b_sel;
   logic       c_start, c_mux, c_busy, c_done;
   logic [3:0] c_in, c_smp;
   logic [1:0] c_sel;

   int n_checks;
   int n_pass;

   // behavioural muxes
   assign a_mux = a_in[a_sel];
   assign b_mux = b_in[b_sel];
   assign c_mux = c_in[c_sel];

   mux_scan_ctrl #(.DWELL(2)) u_a (
      .clk(clk), .rst(rst), .i_start(a_start), .i_mux_out(a_mux),
      .o_sel(a_sel), .o_samples(a_smp), .o_busy(a_busy), .o_done(a_done));
   mux_scan_ctrl #(.DWELL(1)) u_b (
      .clk(clk), .rst(rst), .i_start(b_start), .i_mux_out(b_mux),
      .o_sel(b_sel), .o_samples(b_smp), .o_busy(b_busy), .o_done(b_done));
   mux_scan_ctrl #(.DWELL(255)) u_c (
      .clk(clk), .rst(rst), .i_start(c_start), .i_mux_out(c_mux),
      .o_sel(c_sel), .o_samples(c_smp), .o_busy(c_busy), .o_done(c_done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      a_start = 1'b0;
      b_start = 1'b0;
      c_start = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Expected outputs c cycles after the edge that accepted start (c>=1), for dwell d and
   // mux inputs v. Each channel occupies d+1 cycles; channel n is captured at the end of
   // cycle (n+1)*(d+1), so it is visible from the following cycle.
   function automatic void model(input int c, input int d, input logic [3:0] v,
                                 output logic [1:0] s, output logic [3:0] smp,
                                 output logic b, output logic dn);
      int per;
      int last;
      per  = d + 1;
      last = 4 * per;
      if (c >= 1 && c <= last) begin
         b   = 1'b1;
         dn  = 1'b0;
         s   = 2'((c - 1) / per);
         smp = 4'b0000;
         for (int n = 0; n < 4; n++) begin
            if ((n + 1) * per < c) smp[n] = v[n];
         end
      end else if (c == last + 1) begin
         b = 1'b1; dn = 1'b1; s = 2'd3; smp = v;
      end else begin
         b = 1'b0; dn = 1'b0; s = 2'd3; smp = v;
      end
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      a_start = 1'b1;
      b_start = 1'b0;
      c_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if ({a_sel, a_smp, a_busy, a_done} !== 8'b00_0000_00) begin
            $display("FAIL reset_hold cyc=%0d got sel=%0d smp=%b busy=%b done=%b required 0/0000/0/0",
                     i, a_sel, a_smp, a_busy, a_done);
         end else n_pass++;
      end
      rst = 1'b0;
      a_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if ({a_sel, a_smp, a_busy, a_done} !== 8'b00_0000_00) begin
            $display("FAIL reset_after cyc=%0d got sel=%0d smp=%b busy=%b done=%b required 0/0000/0/0",
                     i, a_sel, a_smp, a_busy, a_done);
         end else n_pass++;
      end
   endtask

   task automatic test_basic_scan();
      logic [1:0] es; logic [3:0] esm; logic eb, ed;
      int ndone;
      int done_at;
      do_reset();
      a_in = 4'b1010;
      ndone = 0;
      done_at = -1;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         model(c, 2, 4'b1010, es, esm, eb, ed);
         if (a_done === 1'b1) begin ndone++; done_at = c; end
         n_checks++;
         if ({a_sel, a_smp, a_busy, a_done} !== {es, esm, eb, ed}) begin
            $display("FAIL basic c=%0d got sel=%0d smp=%b busy=%b done=%b required sel=%0d smp=%b busy=%b done=%b",
                     c, a_sel, a_smp, a_busy, a_done, es, esm, eb, ed);
         end else n_pass++;
         tick();
      end
      n_checks++;
      if (ndone != 1 || done_at != 13) begin
         $display("FAIL basic_done got count=%0d at=%0d required count=1 at=13", ndone, done_at);
      end else n_pass++;
   endtask

   task automatic test_ignore_start();
      logic [1:0] es; logic [3:0] esm; logic eb, ed;
      int ndone;
      do_reset();
      a_in = 4'b1010;
      ndone = 0;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         model(c, 2, 4'b1010, es, esm, eb, ed);
         if (a_done === 1'b1) ndone++;
         n_checks++;
         if ({a_sel, a_smp, a_busy, a_done} !== {es, esm, eb, ed}) begin
            $display("FAIL ignore_start c=%0d got sel=%0d smp=%b busy=%b done=%b required sel=%0d smp=%b busy=%b done=%b",
                     c, a_sel, a_smp, a_busy, a_done, es, esm, eb, ed);
         end else n_pass++;
         a_start = (c == 5);
         tick();
      end
      a_start = 1'b0;
      n_checks++;
      if (ndone != 1) begin
         $display("FAIL ignore_start_count got %0d required 1", ndone);
      end else n_pass++;
   endtask

   task automatic test_reset_mid();
      int ndone;
      do_reset();
      a_in = 4'b1111;
      ndone = 0;
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      for (int c = 1; c < 7; c++) tick();
      n_checks++;
      if (a_sel !== 2'd2 || a_busy !== 1'b1) begin
         $display("FAIL mid_pre got sel=%0d busy=%b required sel=2 busy=1", a_sel, a_busy);
      end else n_pass++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if ({a_sel, a_smp, a_busy, a_done} !== 8'b00_0000_00) begin
         $display("FAIL mid_reset got sel=%0d smp=%b busy=%b done=%b required 0/0000/0/0",
                  a_sel, a_smp, a_busy, a_done);
      end else n_pass++;
      for (int i = 0; i < 12; i++) begin
         if (a_done === 1'b1 || a_busy === 1'b1) ndone++;
         tick();
      end
      n_checks++;
      if (ndone != 0) begin
         $display("FAIL mid_quiet got active_cycles=%0d required 0", ndone);
      end else n_pass++;
   endtask

   task automatic test_random();
      logic [1:0] es; logic [3:0] esm; logic eb, ed;
      logic [1:0] prev_s;
      logic [3:0] prev_v;
      logic [3:0] v;
      int gap;
      do_reset();
      prev_s = 2'd0;
      prev_v = 4'b0000;
      for (int f = 0; f < 8; f++) begin
         v = 4'($urandom);
         a_in = v;
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) begin
            n_checks++;
            if ({a_sel, a_smp, a_busy, a_done} !== {prev_s, prev_v, 1'b0, 1'b0}) begin
               $display("FAIL rand_idle f=%0d got sel=%0d smp=%b busy=%b done=%b required sel=%0d smp=%b busy=0 done=0",
                        f, a_sel, a_smp, a_busy, a_done, prev_s, prev_v);
            end else n_pass++;
            tick();
         end
         a_start = 1'b1;
         tick();
         a_start = 1'b0;
         for (int c = 1; c <= 14; c++) begin
            model(c, 2, v, es, esm, eb, ed);
            n_checks++;
            if ({a_sel, a_smp, a_busy, a_done} !== {es, esm, eb, ed}) begin
               $display("FAIL rand f=%0d c=%0d got sel=%0d smp=%b busy=%b done=%b required sel=%0d smp=%b busy=%b done=%b",
                        f, c, a_sel, a_smp, a_busy, a_done, es, esm, eb, ed);
            end else n_pass++;
            // stray starts while busy must be ignored
            a_start = (c <= 12) && ($urandom_range(0, 3) == 0);
            tick();
         end
         a_start = 1'b0;
         prev_s = 2'd3;
         prev_v = v;
      end
   endtask

   task automatic test_back_to_back();
      int done_c[$];
      int busy_low;
      int per;
      int exp_n;
      do_reset();
`ifdef MUX_SCAN_CONT_EN
      per = 9;
`else
      per = 10;
`endif
      b_in = 4'b1111;
      busy_low = 0;
      b_start = 1'b1;
      tick();
      for (int c = 1; c <= 45; c++) begin
         if (b_done === 1'b1) begin
            done_c.push_back(c);
            n_checks++;
            if (b_smp !== 4'b1111) begin
               $display("FAIL b2b_samples c=%0d got %b required 1111", c, b_smp);
            end else n_pass++;
         end
         if (c > 9 && c < 45 && b_busy !== 1'b1) busy_low++;
         tick();
      end
      b_start = 1'b0;
      exp_n = (45 - 9) / per + 1;
      n_checks++;
      if (done_c.size() != exp_n || done_c[0] != 9) begin
         $display("FAIL b2b_count got n=%0d required n=%0d first at 9", done_c.size(), exp_n);
      end else n_pass++;
      for (int i = 1; i < done_c.size(); i++) begin
         n_checks++;
         if (done_c[i] - done_c[i-1] != per) begin
            $display("FAIL b2b_period got %0d required %0d", done_c[i] - done_c[i-1], per);
         end else n_pass++;
      end
      n_checks++;
`ifdef MUX_SCAN_CONT_EN
      if (busy_low != 0) begin
         $display("FAIL b2b_busy_low got %0d required 0", busy_low);
      end else n_pass++;
`else
      if (busy_low != (45 - 10) / per + 1) begin
         $display("FAIL b2b_busy_low got %0d required %0d", busy_low, (45 - 10) / per + 1);
      end else n_pass++;
`endif
   endtask

   task automatic test_dwell255();
      logic [1:0] es; logic [3:0] esm; logic eb, ed;
      logic [3:0] v;
      int errs;
      int done_at;
      do_reset();
      v = 4'($urandom);
      c_in = v;
      errs = 0;
      done_at = -1;
      c_start = 1'b1;
      tick();
      c_start = 1'b0;
      for (int c = 1; c <= 1028; c++) begin
         model(c, 255, v, es, esm, eb, ed);
         if (c_done === 1'b1) done_at = c;
         n_checks++;
         if ({c_sel, c_smp, c_busy, c_done} !== {es, esm, eb, ed}) begin
            if (errs < 5)
               $display("FAIL dwell255 c=%0d got sel=%0d smp=%b busy=%b done=%b required sel=%0d smp=%b busy=%b done=%b",
                        c, c_sel, c_smp, c_busy, c_done, es, esm, eb, ed);
            errs++;
         end else n_pass++;
         tick();
      end
      n_checks++;
      if (done_at != 1025) begin
         $display("FAIL dwell255_done got %0d required 1025", done_at);
      end else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst = 1'b1;
      a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
      a_in = 4'b0000; b_in = 4'b0000; c_in = 4'b0000;
      test_reset();
      test_basic_scan();
      test_ignore_start();
      test_reset_mid();
      test_random();
      test_back_to_back();
      test_dwell255();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
